// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows the shared combinational ALU
// for every add and shift, one ALU operation per cycle, returning the low word.

package alu_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;
endpackage

interface alu_if;
    import alu_pkg::*;

    word_t      port_a;
    word_t      port_b;
    alu_op_t    opcode;
    word_t      port_o;
    alu_flags_t flags;

    // tb: the side that issues operations; alu: the combinational ALU itself
    modport tb  (output port_a, port_b, opcode, input  port_o, flags);
    modport alu (input  port_a, port_b, opcode, output port_o, flags);
endinterface

module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int ITER_MAX = 32
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  word_t multiplicand,
    input  word_t multiplier,
    output logic  busy,
    output logic  done,
    output word_t product,
    alu_if.tb     aluif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    word_t      acc_q, acc_d;
    word_t      mc_q, mc_d;
    word_t      mp_q, mp_d;
    logic [5:0] cnt_q, cnt_d;
    word_t      product_q, product_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    word_t      mp_shr;

    logic unused_flags;
    assign unused_flags = ^aluif.flags;

    assign mp_shr = mp_q >> 1;

    // ALU drive depends only on registered state, so the ALU result can be
    // consumed in the same cycle without a combinational loop through it.
    always_comb begin
        aluif.opcode = ALU_ADD;
        aluif.port_a = '0;
        aluif.port_b = '0;
        case (state_q)
            S_ADD: begin
                aluif.opcode = ALU_ADD;
                aluif.port_a = acc_q;
                aluif.port_b = mc_q;
            end
            S_SHIFT: begin
                aluif.opcode = ALU_SLL;
                aluif.port_a = mc_q;
                aluif.port_b = 32'd1;
            end
            default: begin
                aluif.opcode = ALU_ADD;
                aluif.port_a = '0;
                aluif.port_b = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = (state_q != S_IDLE);
        done_d    = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mc_d    = multiplicand;
                    mp_d    = multiplier;
                    cnt_d   = '0;
                    state_d = (multiplier != '0) ? S_ADD : S_DONE;
                end
            end
            S_ADD: begin
                if (mp_q[0]) begin
                    acc_d = aluif.port_o;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                mc_d  = aluif.port_o;
                mp_d  = mp_shr;
                cnt_d = cnt_q + 6'd1;
                // Stop as soon as no set multiplier bits remain.
                if ((mp_shr == '0) || (cnt_q == 6'(ITER_MAX - 1))) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                product_d = acc_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised bench for alu_mul_seq; a behavioural ALU answers the DUT and
// results, latencies and ALU traffic are predicted from plain arithmetic.

module tb_alu_mul_seq;
    import alu_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  start;
    word_t multiplicand;
    word_t multiplier;
    logic  busy;
    logic  done;
    word_t product;

    int total_cnt = 0;
    int bad_cnt   = 0;

    alu_if aluif();

    always #5 CLK = ~CLK;

    always_comb begin
        word_t r;
        r = '0;
        case (aluif.opcode)
            ALU_ADD: r = aluif.port_a + aluif.port_b;
            ALU_SUB: r = aluif.port_a - aluif.port_b;
            ALU_AND: r = aluif.port_a & aluif.port_b;
            ALU_OR:  r = aluif.port_a | aluif.port_b;
            ALU_XOR: r = aluif.port_a ^ aluif.port_b;
            ALU_SLL: r = aluif.port_a << aluif.port_b[4:0];
            ALU_SRL: r = aluif.port_a >> aluif.port_b[4:0];
            ALU_SRA: r = word_t'($signed(aluif.port_a) >>> aluif.port_b[4:0]);
            default: r = '0;
        endcase
        aluif.port_o      = r;
        aluif.flags       = '0;
        aluif.flags.zero  = (r == '0);
        aluif.flags.neg   = r[31];
    end

    alu_mul_seq #(.ITER_MAX(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .aluif        (aluif)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Number of shift-add iterations: one past the highest set multiplier bit.
    function automatic int exp_iters(input word_t b);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    task automatic check_alu_idle(input string tag);
        check_val({tag, "_op"}, 32'(aluif.opcode), 32'(ALU_ADD));
        check_val({tag, "_a"}, aluif.port_a, 32'd0);
        check_val({tag, "_b"}, aluif.port_b, 32'd0);
    endtask

    // One multiplication. started=1 means the accepting edge has just passed.
    // chain=1 raises start with (na,nb) in the DONE cycle and keeps it high.
    task automatic run_op(input word_t a, input word_t b, input bit started,
                          input int restart_at, input bit chain,
                          input word_t na, input word_t nb);
        int         n;
        int         lat;
        int         e;
        bit         seen;
        word_t      exp_p;
        logic [63:0] m;
        n     = exp_iters(b);
        lat   = 2 * n + 1;
        exp_p = a * b;
        if (!started) begin
            @(negedge CLK);
            start        = 1'b1;
            multiplicand = a;
            multiplier   = b;
            @(posedge CLK);
            #1;
        end
        start = 1'b0;
        e     = 0;
        seen  = 1'b0;
        while (!seen && e <= lat + 4) begin
            if (e < 2 * n) begin
                m = (64'd1 << (e / 2)) - 64'd1;
                if (e % 2 == 0) begin
                    check_val("add_op", 32'(aluif.opcode), 32'(ALU_ADD));
                    check_val("add_a", aluif.port_a, a * (b & m[31:0]));
                    check_val("add_b", aluif.port_b, a << (e / 2));
                end else begin
                    check_val("sll_op", 32'(aluif.opcode), 32'(ALU_SLL));
                    check_val("sll_a", aluif.port_a, a << (e / 2));
                    check_val("sll_b", aluif.port_b, 32'd1);
                end
            end else begin
                check_alu_idle("tail");
            end
            if (e >= 1) check_val("busy_run", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
            end else begin
                multiplicand = $urandom;
                multiplier   = $urandom;
                start        = 1'b0;
                if (e == restart_at) begin
                    start        = 1'b1;
                    multiplicand = 32'd2;
                    multiplier   = 32'd2;
                end
                if (chain && e == lat - 1) begin
                    start        = 1'b1;
                    multiplicand = na;
                    multiplier   = nb;
                end
                @(posedge CLK);
                #1;
                e++;
            end
        end
        if (!seen) begin
            check_val("done_timeout", 32'd0, 32'd1);
        end else begin
            check_val("latency", 32'(e), 32'(lat));
            check_val("product", product, exp_p);
        end
        $display("op 0x%08h * 0x%08h -> 0x%08h after %0d cycles (expect 0x%08h, %0d)",
                 a, b, product, e, exp_p, lat);
        @(posedge CLK);
        #1;
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("busy_gap", 32'(busy), 32'd0);
        check_val("product_hold", product, exp_p);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t a, b, na, nb;
        bit    started, ch;
        RST          = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd7;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_product", product, 32'd0);
        check_alu_idle("rst_alu");
        @(negedge CLK);
        RST   = 1'b0;
        start = 1'b0;
        @(posedge CLK);
        #1;
        check_val("rst_start_dropped", 32'(busy), 32'd0);

        run_op(32'd3, 32'd5, 1'b0, -1, 1'b0, '0, '0);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b0, -1, 1'b0, '0, '0);
        run_op(32'h1234, 32'd0, 1'b0, -1, 1'b0, '0, '0);
        run_op(32'd3, 32'h8000_0000, 1'b0, -1, 1'b0, '0, '0);
        run_op(32'd7, 32'd9, 1'b0, 4, 1'b0, '0, '0);

        // Abort a long operation with reset; the previous product must clear.
        @(negedge CLK);
        start        = 1'b1;
        multiplicand = 32'hFFFF;
        multiplier   = 32'hFFFF;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_product", product, 32'd0);
        check_alu_idle("abort_alu");
        RST = 1'b0;
        $display("reset during 0x0000ffff * 0x0000ffff, product now 0x%08h", product);
        run_op(32'd4, 32'd4, 1'b0, -1, 1'b0, '0, '0);

        a       = $urandom;
        b       = $urandom >> $urandom_range(0, 31);
        started = 1'b0;
        for (int k = 0; k < 16; k++) begin
            na = $urandom;
            nb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) nb = '0;
            ch = (k < 15) && (k % 3 != 2);
            run_op(a, b, started, -1, ch, na, nb);
            started = ch;
            a       = na;
            b       = nb;
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential unsigned multiplier that drives the ALU over `alu_if` from the initiator side. It uses the combinational ALU for every add and shift, one ALU operation per cycle, and produces the low 32 bits of `multiplicand * multiplier`. It sits beside the datapath as a multi-cycle functional unit. The control unit starts it with a `start` pulse and stalls until `done`.

## Interface
Parameters:
- `ITER_MAX`, 32: maximum shift-add iterations (equals word width).

Ports:
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `multiplicand`  in  32 (word_t)  operand A; latched on accepted start.
- `multiplier`  in  32 (word_t)  operand B; latched on accepted start.
- `busy`  out  1  high in ADD, SHIFT and DONE.
- `done`  out  1  one-cycle pulse when `product` is valid.
- `product`  out  32 (word_t)  low 32 bits of result; held until the next completion.
- `aluif`  alu_if.tb  initiator side of the ALU interface:
  - drives `port_a`, `port_b`, `opcode`;
  - consumes `port_o`;
  - flags are unused.

## Operation
Internal registers:
- `acc`, `mc`, `mp`: 32 bits each.
- `cnt`: 6 bits.

States:

IDLE
- ALU driven with `opcode=ALU_ADD`, `port_a=0`, `port_b=0`.
- On `start`: `acc<=0`, `mc<=multiplicand`, `mp<=multiplier`, `cnt<=0`.
- Next state is ADD if `multiplier!=0`, else DONE.

ADD
- Drives `opcode=ALU_ADD`, `port_a=acc`, `port_b=mc`.
- If `mp[0]`: `acc<=port_o`; otherwise `acc` is unchanged.
- Next state: SHIFT.

SHIFT
- Drives `opcode=ALU_SLL`, `port_a=mc`, `port_b=32'd1` (`port_a` is the shifted value, `port_b[4:0]` the shift amount).
- Updates: `mc<=port_o`, `mp<=mp>>1` (internal logical shift), `cnt<=cnt+1`.
- Next state is DONE if `(mp>>1)==0` or `cnt==ITER_MAX-1`, else ADD.

DONE
- `done=1`, `product<=acc` (registered on entry, so `product` is valid in the same cycle `done` is high).
- ALU driven as in IDLE.
- Next state: IDLE.

Rules:
- Arithmetic is modulo 2^32. Carries out of bit 31 and bits shifted out of `mc` are discarded. No overflow indication.
- `start` outside IDLE is ignored, with no queuing. `start` held high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- Operand inputs may change freely after the start is accepted.
- ALU outputs are consumed in the same cycle they are presented. The ALU is combinational, and a registered ALU is not supported.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `product=0`, `acc=mc=mp=0`, `cnt=0`.
- ALU drive under reset: `opcode=ALU_ADD`, `port_a=port_b=0`.
- Let k be the index of the highest set bit of `multiplier`, and n=k+1 iterations.
- Start is accepted at edge 0. State is ADD/SHIFT for 2n cycles, then DONE for 1 cycle. `done` is high in the cycle after edge 2n+1; `busy` drops one cycle later.
- `multiplier==0`: DONE in the cycle after edge 1, with `product=0`.
- Worst case (`multiplier[31]=1`): `done` 65 cycles after acceptance.
- `RST` asserted in any state takes effect at the next edge and returns to the reset values. No `done` is emitted for the aborted operation, and the prior `product` is cleared to 0.
- `RST` and `start` asserted together: `RST` wins and `start` is dropped.
- Back-to-back operation: the minimum spacing between accepted starts is 2n+2 cycles (IDLE is always visited for one cycle).

## Test plan
- Small operands: 3 × 5 → `done` exactly 7 cycles after start accepted (n=3), `product=15`. Bench checks that `opcode` alternates ADD/SLL while busy.
- Wrap-around: 0xFFFFFFFF × 2 → `product=0xFFFFFFFE`, `done` after 5 cycles.
- Zero multiplier: 0x1234 × 0 → `done` after 1 cycle, `product=0`, and no ADD/SHIFT states visited.
- Worst-case latency with truncation: 3 × 0x80000000 → `done` after 65 cycles, `product=0x80000000`.
- Start while busy: 7 × 9, re-pulse `start` with 2 × 2 mid-operation → single `done` with `product=63`; `busy` low for one cycle afterwards before the second request can be accepted.
- Reset mid-operation: start 0xFFFF × 0xFFFF, assert `RST` at cycle 10 → next cycle `busy=0`, `done=0`, `product=0`. A subsequent 4 × 4 yields 16 after 7 cycles.
